// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM encoding and status-register layout for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_FREAD = 8'h0B;
  localparam logic [7:0] CMD_PP    = 8'h02;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_RDID  = 8'h9F;
  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_WRDI  = 8'h04;

  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD,
    ST_PROG,
    ST_STATUS,
    ST_JEDEC,
    ST_IGNORE
  } state_e;

  // WIP is always 0: programming completes instantly in this model.
  function automatic logic [7:0] status_byte(input logic wel_bit);
    logic [7:0] sr;
    sr         = '0;
    sr[SR_WEL] = wel_bit;
    sr[SR_WIP] = 1'b0;
    return sr;
  endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Two-flop synchronizer with a delayed copy of the synchronized level for edge pulses.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash emulator: READ/FAST READ/RDSR/RDID/WREN/WRDI/PP over a byte array.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          MEM_AW   = 8,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic              ld_we,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              active,
  output logic [7:0]        last_cmd,
  output logic              wel
);

  localparam int                PAGE_BITS = (MEM_AW < 8) ? MEM_AW : 8;
  localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'((1 << PAGE_BITS) - 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  // CS chain resets to the asserted level so a CS held low through reset never fakes a frame start.
  spi_edge_sync #(.RST_VAL(1'b0)) u_cs_sync (
    .clk(clk), .rst(rst), .d(spi_cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(spi_sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_edge_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .d(spi_mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q;
  logic [1:0]        byte_cnt_q;
  logic [1:0]        id_idx_q;
  logic [7:0]        shift_q;
  logic [6:0]        tx_shift_q;
  logic              miso_q;
  logic              wel_q;
  logic              cs_armed_q;
  logic [7:0]        last_cmd_q;
  logic [MEM_AW-1:0] addr_q;
  logic [7:0]        rd_data_q;
  logic [7:0]        mem_q [(1 << MEM_AW)];

  logic [7:0]        rx_byte;
  logic              byte_done;
  logic              addr_last;
  logic              tx_active;
  logic [MEM_AW-1:0] addr_shift;
  logic [MEM_AW-1:0] addr_pp;
  logic [7:0]        tx_src;
  logic              mem_we, mem_re;
  logic [MEM_AW-1:0] mem_waddr, mem_raddr;
  logic [7:0]        mem_wdata;

  assign rx_byte    = {shift_q[6:0], mosi_lvl};
  assign byte_done  = sclk_rise && (bit_cnt_q == 3'd7) && (state_q != ST_IDLE);
  assign addr_last  = (byte_cnt_q == 2'd3);
  assign tx_active  = (state_q == ST_RD) || (state_q == ST_STATUS) || (state_q == ST_JEDEC);
  assign addr_shift = {addr_q[MEM_AW-2:0], mosi_lvl};
  // Programming wraps inside the 256-byte page; the page number is untouched.
  assign addr_pp    = (addr_q & ~PAGE_MASK) | ((addr_q + MEM_AW'(1)) & PAGE_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    state_d   = state_q;
    tx_src    = 8'hFF;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = rx_byte;
    mem_re    = 1'b0;
    mem_raddr = addr_q;

    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            case (rx_byte)
              CMD_READ, CMD_FREAD, CMD_PP: state_d = ST_ADDR;
              CMD_RDSR:                    state_d = ST_STATUS;
              CMD_RDID:                    state_d = ST_JEDEC;
              default:                     state_d = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (byte_done && addr_last) begin
            if (last_cmd_q == CMD_FREAD)   state_d = ST_DUMMY;
            else if (last_cmd_q == CMD_PP) state_d = ST_PROG;
            else                           state_d = ST_RD;
          end
        end
        ST_DUMMY: if (byte_done) state_d = ST_RD;
        default: ;
      endcase
    end

    case (state_q)
      ST_RD:     tx_src = rd_data_q;
      ST_STATUS: tx_src = status_byte(wel_q);
      ST_JEDEC: begin
        case (id_idx_q)
          2'd0:    tx_src = JEDEC_ID[23:16];
          2'd1:    tx_src = JEDEC_ID[15:8];
          2'd2:    tx_src = JEDEC_ID[7:0];
          default: tx_src = 8'hFF;
        endcase
      end
      default: ;
    endcase

    // Load port has priority; a colliding PROG byte is simply lost.
    if (ld_we) begin
      mem_we    = 1'b1;
      mem_waddr = ld_addr;
      mem_wdata = ld_data;
    end else if (byte_done && (state_q == ST_PROG) && wel_q) begin
      mem_we = 1'b1;
    end

    // Reads are issued on the final rising edge so the byte is ready before the next falling edge.
    if (byte_done && (state_q == ST_ADDR) && addr_last && (last_cmd_q != CMD_PP)) begin
      mem_re    = 1'b1;
      mem_raddr = addr_shift;
    end else if (byte_done && (state_q == ST_RD)) begin
      mem_re = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      id_idx_q   <= '0;
      shift_q    <= '0;
      tx_shift_q <= '1;
      miso_q     <= 1'b1;
      wel_q      <= 1'b0;
      cs_armed_q <= 1'b0;
      last_cmd_q <= '0;
      addr_q     <= '0;
    end else begin
      if (cs_lvl) cs_armed_q <= 1'b1;

      if (cs_fall) begin
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
        id_idx_q   <= '0;
      end else if (sclk_rise && (state_q != ST_IDLE)) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        shift_q   <= rx_byte;
        if (bit_cnt_q == 3'd7) byte_cnt_q <= byte_cnt_q + 2'd1;
      end

      if (sclk_rise && (state_q == ST_ADDR)) begin
        if (byte_done && addr_last && (last_cmd_q != CMD_PP)) addr_q <= addr_shift + MEM_AW'(1);
        else                                                  addr_q <= addr_shift;
      end
      if (byte_done && (state_q == ST_RD))   addr_q <= addr_q + MEM_AW'(1);
      if (byte_done && (state_q == ST_PROG)) addr_q <= addr_pp;

      if (byte_done && (state_q == ST_CMD)) begin
        last_cmd_q <= rx_byte;
        if (rx_byte == CMD_WREN)      wel_q <= 1'b1;
        else if (rx_byte == CMD_WRDI) wel_q <= 1'b0;
      end
      if (cs_rise && (state_q == ST_PROG)) wel_q <= 1'b0;

      if (sclk_fall) begin
        if (tx_active) begin
          if (bit_cnt_q == 3'd0) begin
            {miso_q, tx_shift_q} <= tx_src;
            if ((state_q == ST_JEDEC) && (id_idx_q != 2'd3)) id_idx_q <= id_idx_q + 2'd1;
          end else begin
            {miso_q, tx_shift_q} <= {tx_shift_q, 1'b1};
          end
        end else begin
          miso_q <= 1'b1;
        end
      end
      if (cs_rise) miso_q <= 1'b1;
    end
  end

  // NOTE: the array and its read register carry no reset so contents survive rst and map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (mem_re) rd_data_q <= mem_q[mem_raddr];
  end

  assign spi_miso = miso_q;
  assign active   = ~cs_lvl & cs_armed_q;
  assign last_cmd = last_cmd_q;
  assign wel      = wel_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: drives mode-0 frames and checks responses against hand-computed bytes.
module tb_spi_flash_responder;
  import spi_flash_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_cs_n, spi_sclk, spi_mosi;
  logic       spi_miso;
  logic       ld_we;
  logic [7:0] ld_addr, ld_data;
  logic       active;
  logic [7:0] last_cmd;
  logic       wel;

  int n_tests = 0;
  int n_fail  = 0;

  spi_flash_responder dut (
    .clk(clk), .rst(rst),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .active(active), .last_cmd(last_cmd), .wel(wel)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    ld_we   = 1'b1;
    wait_clk(1);
    ld_we   = 1'b0;
  endtask

  // One SCLK period per bit: MISO is sampled 3 clk after the falling edge, just before the rise.
  // With collide set, ld_we is pulsed exactly in the cycle the responder commits the last bit.
  task automatic xfer(input logic [7:0] tx, input int nbits, input bit collide, output logic [7:0] rx);
    rx = 8'hFF;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx[i];
      wait_clk(3);
      rx[i] = spi_miso;
      wait_clk(1);
      spi_sclk = 1'b1;
      if (collide && i == 0) begin
        wait_clk(2);
        ld_we = 1'b1;
        wait_clk(1);
        ld_we = 1'b0;
        wait_clk(1);
      end else begin
        wait_clk(4);
      end
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] rx;
    xfer(b, 8, 1'b0, rx);
  endtask

  task automatic recv(output logic [7:0] rx);
    xfer(8'h00, 8, 1'b0, rx);
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_end();
    wait_clk(2);
    spi_cs_n = 1'b1;
    wait_clk(6);
  endtask

  task automatic do_read(input string tag, input logic [23:0] a, input int n, input logic [31:0] exp_word);
    logic [7:0] rx;
    cs_begin();
    send(CMD_READ);
    send(a[23:16]);
    send(a[15:8]);
    send(a[7:0]);
    for (int i = 0; i < n; i++) begin
      recv(rx);
      check($sformatf("%s_byte%0d", tag, i), {24'h0, rx}, {24'h0, exp_word[8*(n-1-i) +: 8]});
    end
    cs_end();
  endtask

  task automatic do_pp(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1);
    cs_begin();
    send(CMD_PP);
    send(a[23:16]);
    send(a[15:8]);
    send(a[7:0]);
    send(d0);
    send(d1);
    cs_end();
  endtask

  task automatic do_single(input logic [7:0] op);
    cs_begin();
    send(op);
    cs_end();
  endtask

  initial begin
    logic [7:0] rx;
    rst      = 1'b1;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    ld_we    = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    wait_clk(3);

    check("rst_miso", {31'h0, spi_miso}, 32'h1);
    check("rst_active", {31'h0, active}, 32'h0);
    check("rst_last_cmd", {24'h0, last_cmd}, 32'h0);
    check("rst_wel", {31'h0, wel}, 32'h0);
    rst = 1'b0;
    wait_clk(6);

    load(8'h00, 8'hAA);
    load(8'h01, 8'hE7);
    load(8'h02, 8'h33);
    load(8'h03, 8'h0F);
    load(8'hFF, 8'h5A);
    load(8'h10, 8'hC3);
    load(8'h11, 8'h3C);
    wait_clk(2);

    // READ with active tracking CS
    cs_begin();
    check("active_cs_low", {31'h0, active}, 32'h1);
    send(CMD_READ);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    recv(rx); check("read_b0", {24'h0, rx}, 32'hAA);
    recv(rx); check("read_b1", {24'h0, rx}, 32'hE7);
    recv(rx); check("read_b2", {24'h0, rx}, 32'h33);
    recv(rx); check("read_b3", {24'h0, rx}, 32'h0F);
    cs_end();
    check("read_last_cmd", {24'h0, last_cmd}, 32'h03);
    check("active_cs_high", {31'h0, active}, 32'h0);

    // FAST READ across the top of the array
    cs_begin();
    send(CMD_FREAD);
    send(8'h00);
    send(8'h00);
    send(8'hFF);
    recv(rx); check("fread_dummy", {24'h0, rx}, 32'hFF);
    recv(rx); check("fread_b0", {24'h0, rx}, 32'h5A);
    recv(rx); check("fread_wrap", {24'h0, rx}, 32'hAA);
    cs_end();

    // Program without WREN is ignored
    do_pp(24'h000010, 8'h11, 8'h22);
    do_read("pp_nowel", 24'h000010, 2, 32'h0000C33C);

    // WREN then program
    do_single(CMD_WREN);
    check("wren_wel", {31'h0, wel}, 32'h1);
    do_pp(24'h000010, 8'h11, 8'h22);
    check("pp_clears_wel", {31'h0, wel}, 32'h0);
    do_read("pp_wel", 24'h000010, 2, 32'h00001122);

    cs_begin();
    send(CMD_RDSR);
    recv(rx); check("rdsr_after_pp", {24'h0, rx}, 32'h00);
    cs_end();

    // Status repeats, JEDEC ID then FF
    do_single(CMD_WREN);
    cs_begin();
    send(CMD_RDSR);
    recv(rx); check("rdsr_b0", {24'h0, rx}, 32'h02);
    recv(rx); check("rdsr_b1", {24'h0, rx}, 32'h02);
    cs_end();

    cs_begin();
    send(CMD_RDID);
    recv(rx); check("rdid_b0", {24'h0, rx}, 32'hEF);
    recv(rx); check("rdid_b1", {24'h0, rx}, 32'h40);
    recv(rx); check("rdid_b2", {24'h0, rx}, 32'h18);
    recv(rx); check("rdid_b3", {24'h0, rx}, 32'hFF);
    cs_end();
    check("rdid_last_cmd", {24'h0, last_cmd}, 32'h9F);
    check("rdid_keeps_wel", {31'h0, wel}, 32'h1);

    do_single(CMD_WRDI);
    check("wrdi_wel", {31'h0, wel}, 32'h0);

    // Abort mid-address
    cs_begin();
    send(CMD_READ);
    xfer(8'h00, 5, 1'b0, rx);
    spi_cs_n = 1'b1;
    wait_clk(3);
    check("abort_idle", 32'(dut.state_q), 32'(ST_IDLE));
    wait_clk(4);
    do_read("after_abort", 24'h000001, 1, 32'h000000E7);

    // Asynchronous reset in the middle of a READ data byte
    do_single(CMD_WREN);
    check("pre_rst_wel", {31'h0, wel}, 32'h1);
    cs_begin();
    send(CMD_READ);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    xfer(8'h00, 1, 1'b0, rx);
    wait_clk(3);
    check("pre_rst_miso", {31'h0, spi_miso}, 32'h0);
    rst = 1'b1;
    #1;
    check("mid_rst_miso", {31'h0, spi_miso}, 32'h1);
    check("mid_rst_active", {31'h0, active}, 32'h0);
    check("mid_rst_wel", {31'h0, wel}, 32'h0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(3);
    spi_cs_n = 1'b1;
    wait_clk(6);
    do_read("after_rst", 24'h000000, 1, 32'h000000AA);

    // Load port and PROG write on the same cycle: load data must stick
    do_single(CMD_WREN);
    cs_begin();
    send(CMD_PP);
    send(8'h00);
    send(8'h00);
    send(8'h10);
    ld_addr = 8'h10;
    ld_data = 8'h5C;
    xfer(8'h99, 8, 1'b1, rx);
    cs_end();
    check("collide_wel", {31'h0, wel}, 32'h0);
    do_read("collide", 24'h000010, 1, 32'h0000005C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
